// File: rtl/paint_brush_writer.sv
// paint_brush_writer: turns a brush request into a clipped, row-major burst of
// single-pixel writes into the paint frame RAM, or sweeps the whole frame
// with code 0 on a clear request.
module paint_brush_writer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic [9:0]        x_in,
    input  logic [8:0]        y_in,
    input  logic [2:0]        color,
    input  logic [2:0]        radius,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wren,
    output logic [2:0]        wr_data
);

    typedef enum logic [1:0] {IDLE, STAMP, CLEAR, DONE} state_t;

    localparam logic [10:0]       X_MAX     = 11'(WIDTH - 1);
    localparam logic [10:0]       Y_MAX     = 11'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t state, state_nx;

    // 11-bit working widths so centre +/- radius can never wrap
    logic [10:0] xw, yw, rw, x_sum, y_sum, x_lo, x_hi, y_lo, y_hi;
    logic        in_range;

    logic [10:0]       x0_q, x1_q, y1_q, cx, cy;
    logic [2:0]        color_q;
    logic [ADDR_W-1:0] row_base, clr_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic [2:0]        hold_data;
    logic              stamp_last, clear_last;

    // clip box of the incoming request against the frame edges
    always_comb begin
        xw       = {1'b0, x_in};
        yw       = {2'b0, y_in};
        rw       = {8'b0, radius};
        x_sum    = xw + rw;
        y_sum    = yw + rw;
        x_lo     = (xw < rw) ? 11'd0 : xw - rw;
        y_lo     = (yw < rw) ? 11'd0 : yw - rw;
        x_hi     = (x_sum > X_MAX) ? X_MAX : x_sum;
        y_hi     = (y_sum > Y_MAX) ? Y_MAX : y_sum;
        in_range = (xw <= X_MAX) && (yw <= Y_MAX);
    end

    assign stamp_last = (cx == x1_q) && (cy == y1_q);
    assign clear_last = (clr_addr == LAST_ADDR);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and RAM port; the port replays its last value when idle
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        wren     = 1'b0;
        wr_addr  = hold_addr;
        wr_data  = hold_data;
        case (state)
            IDLE: begin
                if (clear)      state_nx = CLEAR;
                else if (start) state_nx = in_range ? STAMP : DONE;
            end
            STAMP: begin
                busy    = 1'b1;
                wren    = 1'b1;
                wr_addr = row_base + ADDR_W'(cx);
                wr_data = color_q;
                if (stamp_last) state_nx = DONE;
            end
            CLEAR: begin
                busy    = 1'b1;
                wren    = 1'b1;
                wr_addr = clr_addr;
                wr_data = 3'd0;
                if (clear_last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request latch, pixel/row counters with running row base, clear address
    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cx        <= '0;
            cy        <= '0;
            color_q   <= '0;
            row_base  <= '0;
            clr_addr  <= '0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        clr_addr <= '0;
                    end else if (start) begin
                        x0_q     <= x_lo;
                        x1_q     <= x_hi;
                        y1_q     <= y_hi;
                        cx       <= x_lo;
                        cy       <= y_lo;
                        color_q  <= color;
                        row_base <= ADDR_W'(y_lo) * WIDTH_A;
                    end
                end
                STAMP: begin
                    if (cx == x1_q) begin
                        cx       <= x0_q;
                        cy       <= cy + 11'd1;
                        row_base <= row_base + WIDTH_A;
                    end else begin
                        cx <= cx + 11'd1;
                    end
                end
                CLEAR:   clr_addr <= clr_addr + 1'b1;
                default: ;
            endcase
            if (wren) begin
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_paint_brush_writer.sv
// Bench for paint_brush_writer: a full-size instance for the brush cases and a
// small-frame instance so a complete clear sweep fits in a short run.
module tb_paint_brush_writer;

    localparam int SW = 20;
    localparam int SH = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        b_start, b_clear, s_start, s_clear;
    logic [9:0]  b_x, s_x;
    logic [8:0]  b_y, s_y;
    logic [2:0]  b_col, b_rad, s_col, s_rad;
    logic        b_busy, b_done, b_wren, s_busy, s_done, s_wren;
    logic [18:0] b_addr;
    logic [7:0]  s_addr;
    logic [2:0]  b_data, s_data;

    int n_chk = 0;
    int n_fail = 0;

    paint_brush_writer dut_b (
        .clk(clk), .reset(reset), .start(b_start), .clear(b_clear),
        .x_in(b_x), .y_in(b_y), .color(b_col), .radius(b_rad),
        .busy(b_busy), .done(b_done), .wr_addr(b_addr), .wren(b_wren), .wr_data(b_data));

    paint_brush_writer #(.WIDTH(SW), .HEIGHT(SH), .ADDR_W(8)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .clear(s_clear),
        .x_in(s_x), .y_in(s_y), .color(s_col), .radius(s_rad),
        .busy(s_busy), .done(s_done), .wr_addr(s_addr), .wren(s_wren), .wr_data(s_data));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int inst, input int x, input int y, input int c,
                         input int r, input bit st, input bit cl);
        if (inst == 0) begin
            b_x = 10'(x); b_y = 9'(y); b_col = 3'(c); b_rad = 3'(r); b_start = st; b_clear = cl;
        end else begin
            s_x = 10'(x); s_y = 9'(y); s_col = 3'(c); s_rad = 3'(r); s_start = st; s_clear = cl;
        end
    endtask

    task automatic sample(input int inst, output bit w, output int a, output int d,
                          output bit bz, output bit dn);
        if (inst == 0) begin
            w = b_wren; a = int'(b_addr); d = int'(b_data); bz = b_busy; dn = b_done;
        end else begin
            w = s_wren; a = int'(s_addr); d = int'(s_data); bz = s_busy; dn = s_done;
        end
    endtask

    // One request end to end. Expected pixels come from the brush square
    // intersected with the frame, listed row by row.
    task automatic run_req(input string tag, input int inst, input int x, input int y,
                           input int c, input int r, input bit clr, input bit poke,
                           output int first_a, output int last_a);
        int W, H, n, ed, cyc, nw, nbusy, dcyc, bad, a, d;
        bit w, bz, dn;
        int q[$];
        W = (inst == 0) ? 640 : SW;
        H = (inst == 0) ? 480 : SH;
        ed = clr ? 0 : c;
        if (clr) begin
            for (int k = 0; k < W * H; k++) q.push_back(k);
        end else if (x < W && y < H) begin
            for (int row = y - r; row <= y + r; row++)
                for (int col = x - r; col <= x + r; col++)
                    if (row >= 0 && row < H && col >= 0 && col < W) q.push_back(row * W + col);
        end
        n = q.size();
        first_a = -1; last_a = -1;
        @(negedge clk);
        drive(inst, x, y, c, r, 1'b1, clr);
        @(negedge clk);
        drive(inst, x, y, c, r, 1'b0, 1'b0);
        cyc = 1; nw = 0; nbusy = 0; dcyc = -1; bad = 0;
        while (cyc <= n + 10) begin
            sample(inst, w, a, d, bz, dn);
            if (w) begin
                if (nw == 0) first_a = a;
                last_a = a;
                if (nw >= n || a != q[nw] || d != ed || cyc != nw + 1) bad++;
                nw++;
            end
            if (bz) nbusy++;
            if (dn) begin
                dcyc = cyc;
                break;
            end
            // a second request while busy must be ignored
            if (poke && cyc == 3) drive(inst, 5, 5, 7, 7, 1'b1, 1'b0);
            if (poke && cyc == 4) drive(inst, 5, 5, 7, 7, 1'b0, 1'b0);
            @(negedge clk);
            cyc++;
        end
        drive(inst, x, y, c, r, 1'b0, 1'b0);
        chk({tag, "_writes"}, nw, n);
        chk({tag, "_pixels"}, bad, 0);
        chk({tag, "_done_cyc"}, dcyc, n + 1);
        chk({tag, "_busy_cyc"}, nbusy, n);
        @(negedge clk);
        sample(inst, w, a, d, bz, dn);
        chk({tag, "_done_pulse"}, {31'd0, dn} + {31'd0, w}, 0);
    endtask

    initial begin
        int fa, la, bad, dn_cnt, a, d, cyc;
        bit w, bz, dn;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
        drive(1, 0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", b_busy, 0);
        chk("rst_done", b_done, 0);
        chk("rst_wren", b_wren, 0);
        chk("rst_addr", b_addr, 0);
        chk("rst_data", b_data, 0);
        chk("rst_s_wren", s_wren, 0);
        reset = 1'b0;

        run_req("single", 0, 10, 20, 1, 0, 0, 0, fa, la);
        chk("single_addr", fa, 12810);
        run_req("r2", 0, 100, 50, 3, 2, 0, 0, fa, la);
        chk("r2_first", fa, 30818);
        chk("r2_last", la, 33382);
        run_req("corner", 0, 0, 0, 5, 3, 0, 0, fa, la);
        chk("corner_last", la, 1923);
        run_req("far", 0, 639, 479, 2, 1, 0, 0, fa, la);
        chk("far_first", fa, 306558);
        chk("far_last", la, 307199);
        run_req("oor", 0, 700, 10, 4, 1, 0, 0, fa, la);
        run_req("poke", 0, 300, 200, 6, 3, 0, 1, fa, la);
        run_req("s_clear", 1, 3, 3, 5, 1, 1, 0, fa, la);
        chk("s_clear_last", la, SW * SH - 1);
        run_req("s_edge", 1, SW - 1, SH - 1, 7, 7, 0, 0, fa, la);

        // full-size clear: start+clear together, check the leading part, then abort
        @(negedge clk);
        drive(0, 10, 10, 5, 2, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 10, 10, 5, 2, 1'b0, 1'b0);
        bad = 0;
        for (int k = 1; k <= 2000; k++) begin
            sample(0, w, a, d, bz, dn);
            if (!w || !bz || dn || a != k - 1 || d != 0) bad++;
            if (k < 2000) @(negedge clk);
        end
        chk("bclear_seq", bad, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("bclear_abort", {31'd0, b_busy} + {31'd0, b_wren}, 0);

        // reset in cycle 5 of a radius-2 stamp
        @(negedge clk);
        drive(0, 100, 50, 3, 2, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 100, 50, 3, 2, 1'b0, 1'b0);
        for (cyc = 1; cyc < 5; cyc++) @(negedge clk);
        chk("mid_wren_c5", b_wren, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_wren", b_wren, 0);
        chk("mid_busy", b_busy, 0);
        dn_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (b_done || b_wren) dn_cnt++;
            @(negedge clk);
        end
        chk("mid_no_done", dn_cnt, 0);
        run_req("after_rst", 0, 100, 50, 3, 2, 0, 0, fa, la);

        // randomized requests on both frames
        for (int k = 0; k < 25; k++)
            run_req("rnd_b", 0, int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, k % 5 == 0, fa, la);
        for (int k = 0; k < 15; k++)
            run_req("rnd_s", 1, int'($urandom_range(0, SW + 4)), int'($urandom_range(0, SH + 3)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, 0, fa, la);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
